text_buffer_ctrl: RTL and testbench
===================================

// Module: text_buffer_ctrl
// PURPOSE
//  Write-side sequencer for the 32x4 character RAM feeding the VGA text renderer.
//  Takes received UART bytes and owns the cursor. Prints printable ASCII and
//  interprets CR/LF/BS/FF. Runs a full-screen blank sweep on request.
//  Sits between the uart receiver (behind a single pulser) and the RAM write port.
// PARAMETERS
//  COLS   32     characters per row (power of two)
//  ROWS   4      rows on screen (power of two)
//  COL_W  5      log2(COLS), width of column index
//  ROW_W  2      log2(ROWS), width of row index
//  BLANK  8'h20  fill byte for clear and backspace
// PORTS
//  clk        in   1      system clock, 100 MHz
//  reset      in   1      asynchronous, active-high
//  rx_data    in   8      received byte, valid with rx_valid
//  rx_valid   in   1      one-cycle strobe, one byte per strobe
//  clear_req  in   1      one-cycle strobe, start blank sweep
//  ram_we     out  1      RAM write enable, one-cycle pulse per write
//  ram_row    out  ROW_W  RAM write row
//  ram_col    out  COL_W  RAM write column
//  ram_wdata  out  8      RAM write data
//  cur_row    out  ROW_W  current cursor row
//  cur_col    out  COL_W  current cursor column
//  busy       out  1      high while in CLEAR
//  drop_cnt   out  8      count of dropped bytes, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, pending slot empty. Reset mid-sweep aborts it;
//   partially cleared RAM contents are not restored.
//  All outputs are registered. A byte accepted at edge E drives ram_* in the cycle
//   after E and updates cur_* at E. Throughput: 1 byte/cycle in IDLE.
//  FSM IDLE, byte decode at accept edge (p = cursor before E):
//   - 0x20..0x7E: write byte at p; advance col. col==COLS-1 -> col 0, row+1.
//     row==ROWS-1 wraps to row 0.
//   - 0x0D CR: col<=0, no write.
//   - 0x0A LF: col<=0, row<=row+1 (wraps), no write.
//   - 0x08 BS: move back one cell and write BLANK at the new position.
//     col>0 -> (row,col-1). col==0,row>0 -> (row-1,COLS-1). At (0,0): no-op, no write.
//   - 0x0C FF: same as clear_req.
//   - Any other byte: ignored, cursor unchanged, no write.
//  FSM IDLE -> CLEAR on clear_req or FF.
//   CLEAR: sweep counter idx 0..COLS*ROWS-1, one BLANK write per cycle.
//    row=idx[COL_W+:ROW_W], col=idx[COL_W-1:0]. busy=1 for exactly COLS*ROWS cycles.
//   After the last write: cursor<=(0,0), FSM->IDLE.
//   clear_req during CLEAR is ignored (no restart).
//  Pending slot (1 entry):
//   - rx_valid while in CLEAR, or together with clear_req in IDLE: byte goes to
//     the slot (clear wins).
//   - A byte arriving while the slot is full is dropped; drop_cnt+1, saturating.
//   - The slot is processed on the first IDLE cycle after CLEAR, with the same
//     decode and latency. A new rx_valid in that cycle goes back into the slot.
//  Pending FF is processed normally and starts another sweep.
//  busy falls in the same cycle the pending byte's ram_we rises.
// TESTING
//  1. Reset, send 'A','B' on back-to-back cycles -> writes (0,0)=41, (0,1)=42
//     on consecutive cycles; cursor (0,2).
//  2. Send 33 printable bytes -> the 33rd lands at (1,0).
//     From (3,31), one byte -> write at (3,31), cursor (0,0).
//  3. Cursor (1,0), send 0x08 -> write 20 at (0,31), cursor (0,31).
//     At (0,0), send 0x08 -> no write.
//  4. Cursor (2,5): send 0x0D -> (2,0), no write. Then 0x0A -> (3,0).
//     Then 0x07 -> no write, no move.
//  5. clear_req pulse -> busy high 128 cycles, 128 writes of 20 in raster order.
//     Then cursor (0,0) and busy low.
//  6. During CLEAR send 'X','Y','Z' -> 'X' written at (0,0) right after the sweep.
//     drop_cnt=2. Assert reset mid-sweep -> ram_we 0, cursor (0,0) immediately.

Source files
------------

// File: rtl/text_buffer_ctrl_if.sv
// Bus between the UART byte source / RAM write port and the text buffer sequencer.
interface text_buffer_ctrl_if #(
    parameter int ROW_W = 2,
    parameter int COL_W = 5
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             clear_req;
    logic             ram_we;
    logic [ROW_W-1:0] ram_row;
    logic [COL_W-1:0] ram_col;
    logic [7:0]       ram_wdata;
    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             busy;
    logic [7:0]       drop_cnt;

    // Byte source / observer side
    modport master (
        output rx_data, rx_valid, clear_req,
        input  ram_we, ram_row, ram_col, ram_wdata, cur_row, cur_col, busy, drop_cnt
    );

    // Sequencer side
    modport slave (
        input  rx_data, rx_valid, clear_req,
        output ram_we, ram_row, ram_col, ram_wdata, cur_row, cur_col, busy, drop_cnt
    );
endinterface

// File: rtl/text_buffer_ctrl.sv
// Write-side sequencer for the character RAM of the VGA text renderer.
// Decodes received bytes into cursor moves and RAM writes, and runs a
// full-screen blank sweep on request with a one-entry pending byte slot.
module text_buffer_ctrl #(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 4,
    parameter int         COL_W = 5,
    parameter int         ROW_W = 2,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic                clk,
    input  logic                reset,
    text_buffer_ctrl_if.slave   bus
);
    localparam int IDX_W = COL_W + ROW_W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COLS * ROWS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    // Cursor and write address are kept as {row, col}; with power-of-two
    // dimensions a plain increment/decrement gives the raster wrap rules.
    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_pos;
    logic             r_pend_v;
    logic [7:0]       r_pend_d;
    logic [7:0]       r_drop;
    logic             r_we;
    logic [IDX_W-1:0] r_wpos;
    logic [7:0]       r_wdata;
    logic             r_busy;

    logic             w_idle;
    logic             w_consume;
    logic             w_rx_to_slot;
    logic             w_dec_vld;
    logic [7:0]       w_dec_byte;
    logic             w_dec_we;
    logic [IDX_W-1:0] w_dec_wpos;
    logic [7:0]       w_dec_data;
    logic [IDX_W-1:0] w_dec_next;
    logic             w_dec_ff;
    logic             w_go_clear;
    logic [ROW_W-1:0] w_row_inc;

    assign w_idle       = (r_state == S_IDLE);
    // clear_req wins over both the pending byte and a new byte in IDLE
    assign w_consume    = w_idle && !bus.clear_req && r_pend_v;
    assign w_rx_to_slot = bus.rx_valid && (!w_idle || bus.clear_req || r_pend_v);
    assign w_dec_vld    = w_idle && !bus.clear_req && (r_pend_v || bus.rx_valid);
    assign w_dec_byte   = r_pend_v ? r_pend_d : bus.rx_data;
    assign w_row_inc    = r_pos[COL_W +: ROW_W] + ROW_W'(1);
    assign w_go_clear   = w_idle && (bus.clear_req || w_dec_ff);

    // Byte decode: write request and next cursor for the byte taken this cycle
    always_comb begin
        w_dec_we   = 1'b0;
        w_dec_wpos = r_pos;
        w_dec_data = w_dec_byte;
        w_dec_next = r_pos;
        w_dec_ff   = 1'b0;
        if (w_dec_vld) begin
            if (w_dec_byte >= 8'h20 && w_dec_byte <= 8'h7E) begin
                w_dec_we   = 1'b1;
                w_dec_next = r_pos + IDX_W'(1);
            end else if (w_dec_byte == 8'h0D) begin
                w_dec_next[COL_W-1:0] = '0;
            end else if (w_dec_byte == 8'h0A) begin
                w_dec_next = {w_row_inc, {COL_W{1'b0}}};
            end else if (w_dec_byte == 8'h08) begin
                if (r_pos != '0) begin
                    w_dec_next = r_pos - IDX_W'(1);
                    w_dec_we   = 1'b1;
                    w_dec_wpos = r_pos - IDX_W'(1);
                    w_dec_data = BLANK;
                end
            end else if (w_dec_byte == 8'h0C) begin
                w_dec_ff = 1'b1;
            end
        end
    end

    // FSM, cursor and registered RAM write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pos   <= '0;
            r_we    <= 1'b0;
            r_wpos  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_busy <= !w_idle || w_go_clear;
            if (!w_idle) begin
                r_we    <= 1'b1;
                r_wpos  <= r_idx;
                r_wdata <= BLANK;
                r_idx   <= r_idx + IDX_W'(1);
                if (r_idx == IDX_LAST) begin
                    r_state <= S_IDLE;
                    r_pos   <= '0;
                end
            end else if (w_go_clear) begin
                // The first blank write is issued on entry so busy and the
                // sweep writes cover the same COLS*ROWS cycles.
                r_state <= S_CLEAR;
                r_we    <= 1'b1;
                r_wpos  <= '0;
                r_wdata <= BLANK;
                r_idx   <= IDX_W'(1);
            end else if (w_dec_vld) begin
                r_we    <= w_dec_we;
                r_wpos  <= w_dec_wpos;
                r_wdata <= w_dec_data;
                r_pos   <= w_dec_next;
            end
        end
    end

    // Pending slot fill/drain and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_v <= 1'b0;
            r_pend_d <= '0;
            r_drop   <= '0;
        end else begin
            if (w_rx_to_slot) begin
                if (!r_pend_v || w_consume) begin
                    r_pend_v <= 1'b1;
                    r_pend_d <= bus.rx_data;
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end else if (w_consume) begin
                r_pend_v <= 1'b0;
            end
        end
    end

    assign bus.ram_we    = r_we;
    assign bus.ram_row   = r_wpos[COL_W +: ROW_W];
    assign bus.ram_col   = r_wpos[COL_W-1:0];
    assign bus.ram_wdata = r_wdata;
    assign bus.cur_row   = r_pos[COL_W +: ROW_W];
    assign bus.cur_col   = r_pos[COL_W-1:0];
    assign bus.busy      = r_busy;
    assign bus.drop_cnt  = r_drop;
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Scoreboard bench for text_buffer_ctrl: a linear-position screen model
// predicts RAM writes and cursor/busy/drop state; a negedge monitor compares.
module tb_text_buffer_ctrl;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    text_buffer_ctrl_if #(.ROW_W(2), .COL_W(5)) bus();

    text_buffer_ctrl #(
        .COLS(32), .ROWS(4), .COL_W(5), .ROW_W(2), .BLANK(8'h20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec  = 0;
    int  n_fail = 0;

    // model state: cursor as linear cell number 0..127
    int  m_pos   = 0;
    int  m_sweep = 0;   // sweep writes still to come after the current one
    bit  m_pend_v = 0;
    int  m_pend  = 0;
    int  m_drop  = 0;
    bit  m_busy  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int p, input int d);
        wr_t w;
        w.row = p / 32;
        w.col = p % 32;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic start_sweep();
        push_wr(0, 32);
        m_sweep = 127;
        m_busy = 1;
    endtask

    task automatic to_slot(input bit v, input int d);
        if (!v) return;
        if (m_pend_v) begin
            if (m_drop < 255) m_drop++;
        end else begin
            m_pend_v = 1;
            m_pend = d;
        end
    endtask

    task automatic apply_byte(input int b);
        if (b >= 32 && b <= 126) begin
            push_wr(m_pos, b);
            m_pos = (m_pos + 1) % 128;
        end else if (b == 13) begin
            m_pos = m_pos - (m_pos % 32);
        end else if (b == 10) begin
            m_pos = ((m_pos / 32 + 1) % 4) * 32;
        end else if (b == 8) begin
            if (m_pos > 0) begin
                m_pos = m_pos - 1;
                push_wr(m_pos, 32);
            end
        end else if (b == 12) begin
            start_sweep();
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_sweep = 0; m_pend_v = 0; m_pend = 0; m_drop = 0; m_busy = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus; inputs are strobes, dropped after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit c);
        int b;
        @(negedge clk);
        #2;
        bus.rx_valid  = v;
        bus.rx_data   = d;
        bus.clear_req = c;
        m_busy = 0;
        if (m_sweep > 0) begin
            push_wr(128 - m_sweep, 32);
            m_busy = 1;
            m_sweep--;
            if (m_sweep == 0) m_pos = 0;
            to_slot(v, int'(d));
        end else if (c) begin
            start_sweep();
            to_slot(v, int'(d));
        end else if (m_pend_v) begin
            b = m_pend;
            m_pend_v = 0;
            to_slot(v, int'(d));
            apply_byte(b);
        end else if (v) begin
            apply_byte(int'(d));
        end
        @(posedge clk);
        #1;
        bus.rx_valid  = 1'b0;
        bus.clear_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_we", int'(bus.ram_we), 0);
        chk("rst_cursor", int'({bus.cur_row, bus.cur_col}), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_drop", int'(bus.drop_cnt), 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic send_str(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'(8'h41 + (i % 26)), 1'b0);
    endtask

    // Monitor: pop and compare on every DUT write, check state every cycle
    always @(negedge clk) begin
        wr_t e;
        if (bus.ram_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_row", int'(bus.ram_row), e.row);
                chk("wr_col", int'(bus.ram_col), e.col);
                chk("wr_data", int'(bus.ram_wdata), e.data);
            end
        end else if (exp_q.size() != 0) begin
            chk("missing_write", 0, exp_q.size());
            exp_q.delete();
        end
        chk("cursor", int'({bus.cur_row, bus.cur_col}), m_pos);
        chk("busy", int'(bus.busy), int'(m_busy));
        chk("drop_cnt", int'(bus.drop_cnt), m_drop);
    end

    initial begin
        int n_busy;
        int r;
        logic [7:0] d;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.clear_req = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;

        // back-to-back printable bytes
        step(1'b1, 8'h41, 1'b0);
        step(1'b1, 8'h42, 1'b0);
        chk("t1_cursor", int'({bus.cur_row, bus.cur_col}), 2);

        // row wrap and screen wrap
        do_reset();
        send_str(33);
        chk("t2_cursor33", int'({bus.cur_row, bus.cur_col}), 33);
        send_str(94);
        chk("t2_cursor_last", int'({bus.cur_row, bus.cur_col}), 127);
        step(1'b1, 8'h5A, 1'b0);
        chk("t2_wrap", int'({bus.cur_row, bus.cur_col}), 0);

        // backspace across a row and at home
        do_reset();
        send_str(32);
        step(1'b1, 8'h08, 1'b0);
        chk("t3_bs_cursor", int'({bus.cur_row, bus.cur_col}), 31);
        do_reset();
        step(1'b1, 8'h08, 1'b0);
        chk("t3_bs_home_nowrite", int'(bus.ram_we), 0);

        // CR, LF, ignored control
        do_reset();
        send_str(69);
        step(1'b1, 8'h0D, 1'b0);
        chk("t4_cr", int'({bus.cur_row, bus.cur_col}), 64);
        step(1'b1, 8'h0A, 1'b0);
        chk("t4_lf", int'({bus.cur_row, bus.cur_col}), 96);
        step(1'b1, 8'h07, 1'b0);
        chk("t4_bel_nowrite", int'(bus.ram_we), 0);

        // clear sweep length
        step(1'b0, 8'h00, 1'b1);
        n_busy = int'(bus.busy);
        for (int i = 0; i < 139; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (bus.busy) n_busy++;
        end
        chk("t5_busy_len", n_busy, 128);
        chk("t5_cursor", int'({bus.cur_row, bus.cur_col}), 0);

        // bytes during sweep, then reset mid-sweep
        do_reset();
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h58, 1'b0);
        step(1'b1, 8'h59, 1'b0);
        step(1'b1, 8'h5A, 1'b1);
        idle(130);
        chk("t6_drop", int'(bus.drop_cnt), 2);
        chk("t6_cursor", int'({bus.cur_row, bus.cur_col}), 1);
        step(1'b1, 8'h0C, 1'b0);
        idle(10);
        do_reset();

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      d = 8'($urandom_range(32, 126));
            else if (r < 77) d = 8'h0D;
            else if (r < 84) d = 8'h0A;
            else if (r < 93) d = 8'h08;
            else if (r < 95) d = 8'h0C;
            else if (r < 97) d = 8'h07;
            else             d = 8'($urandom_range(127, 255));
            step(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 199) == 0));
        end
        idle(140);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
